rcv_coef_ctrl: RTL and testbench

RCV_COEF_CTRL -- requirements
Module: rcv_coef_ctrl

---
 rtl/rcv_pkg.sv | 26 ++
 rtl/rcv_sam_strobe.sv | 28 ++
 rtl/rcv_coef_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rcv_coef_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared constants, default coefficient set and FSM state encoding for the
// receive-filter coefficient controller.
package rcv_pkg;

  localparam int NTAPS = 11;
  localparam int CW    = 18;
  localparam int DIV   = 4;

  // Power-up coefficient set, b[0] .. b[10], signed 0s18.
  localparam int DEF_COEF [NTAPS] = '{
    4094, 5900, 3326, -3449, -10679, -12462, -4029, 14915, 38991, 59143, 66990
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  // Default coefficient for tap i; taps beyond the table reset to zero.
  function automatic int def_coef(input int i);
    return (i >= 0 && i < NTAPS) ? DEF_COEF[i] : 0;
  endfunction

endpackage

// File: rtl/rcv_sam_strobe.sv
// Free-running sample strobe: high for one clock out of every DIV.
module rcv_sam_strobe #(
  parameter int DIV = rcv_pkg::DIV
) (
  input  logic clk,
  input  logic reset,
  output logic sam_en
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] CNT_LAST = SW'(DIV - 1);

  logic [SW-1:0] cnt;

  // Count 0 .. DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + SW'(1);
    end
  end

  assign sam_en = (cnt == CNT_LAST);

endmodule

// File: rtl/rcv_coef_ctrl.sv
// Double-buffered coefficient controller for the receive FIR.
// Words are streamed into the shadow bank; a commit swaps shadow and active
// on a sample strobe so the filter never sees a half-updated set.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first word of a load (idx = 0)
// LOAD   | accepting words into shadow[idx]
// ARMED  | full shadow set loaded, waiting for commit and sample strobe
// SWAP   | one-cycle exchange of active and shadow banks
module rcv_coef_ctrl
  import rcv_pkg::*;
#(
  parameter int NTAPS = rcv_pkg::NTAPS,
  parameter int CW    = rcv_pkg::CW,
  parameter int DIV   = rcv_pkg::DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [CW-1:0]       cfg_data,
  input  logic                cfg_last,
  output logic                cfg_ready,
  input  logic                cfg_abort,
  input  logic                commit_req,
  output logic                commit_ack,
  output logic                err_len,
  output logic                sam_en,
  output logic                bank_sel,
  output logic [NTAPS*CW-1:0] coef_flat
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NTAPS - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          pend, pend_nxt;
  logic          shd_vld, shd_vld_nxt;
  logic          wr_en;
  logic          swap;
  logic          err_nxt;
  logic          xfer;

  logic [CW-1:0] act_q [NTAPS];
  logic [CW-1:0] shd_q [NTAPS];

  rcv_sam_strobe #(.DIV(DIV)) u_sam (
    .clk    (clk),
    .reset  (reset),
    .sam_en (sam_en)
  );

  assign cfg_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign xfer      = cfg_valid && cfg_ready;

  // Next-state logic: load sequencing, length checking, commit and abort.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pend_nxt    = pend;
    shd_vld_nxt = shd_vld;
    wr_en       = 1'b0;
    swap        = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          wr_en       = 1'b1;
          shd_vld_nxt = 1'b0;
          if (cfg_last) begin
            err_nxt = 1'b1;
          end else begin
            idx_nxt   = IW'(1);
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // Abort wins over a transfer offered in the same cycle.
        if (cfg_abort) begin
          idx_nxt     = '0;
          pend_nxt    = 1'b0;
          shd_vld_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (xfer) begin
          wr_en = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            if (cfg_last) begin
              shd_vld_nxt = 1'b1;
              state_nxt   = ST_ARMED;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (cfg_last) begin
            idx_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      ST_ARMED: begin
        if (cfg_abort) begin
          pend_nxt    = 1'b0;
          shd_vld_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else if ((pend || commit_req) && sam_en && shd_vld) begin
          pend_nxt  = 1'b0;
          state_nxt = ST_SWAP;
        end else if (commit_req) begin
          pend_nxt = 1'b1;
        end
      end
      ST_SWAP: begin
        swap      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pend       <= 1'b0;
      shd_vld    <= 1'b1;
      bank_sel   <= 1'b0;
      commit_ack <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pend       <= pend_nxt;
      shd_vld    <= shd_vld_nxt;
      bank_sel   <= bank_sel ^ swap;
      commit_ack <= swap;
      err_len    <= err_nxt;
    end
  end

  // Coefficient banks: the active bank only changes in SWAP, so the
  // filter output is always driven straight from stable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        act_q[i] <= CW'(def_coef(i));
        shd_q[i] <= CW'(def_coef(i));
      end
    end else if (swap) begin
      for (int i = 0; i < NTAPS; i++) begin
        act_q[i] <= shd_q[i];
        shd_q[i] <= act_q[i];
      end
    end else if (wr_en) begin
      for (int i = 0; i < NTAPS; i++) begin
        if (idx == IW'(i)) begin
          shd_q[i] <= cfg_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NTAPS; g++) begin : g_flat
    assign coef_flat[g*CW +: CW] = act_q[g];
  end

endmodule

// File: tb/tb_rcv_coef_ctrl.sv
// Directed bench for rcv_coef_ctrl: a vector table for length errors and
// ignored commits, plus hand-written load/commit/abort/reset sequences.
module tb_rcv_coef_ctrl;

  localparam int NTAPS = 11;
  localparam int CW    = 18;
  localparam int DIV   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_valid;
  logic [CW-1:0]       cfg_data;
  logic                cfg_last;
  logic                cfg_ready;
  logic                cfg_abort;
  logic                commit_req;
  logic                commit_ack;
  logic                err_len;
  logic                sam_en;
  logic                bank_sel;
  logic [NTAPS*CW-1:0] coef_flat;

  rcv_coef_ctrl #(.NTAPS(NTAPS), .CW(CW), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .err_len    (err_len),
    .sam_en     (sam_en),
    .bank_sel   (bank_sel),
    .coef_flat  (coef_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [CW-1:0] d;
    logic          last;
    logic          abort;
    logic          commit;
    logic          exp_ready;
    logic          exp_err;
    logic          exp_ack;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int def_tab [NTAPS] = '{4094, 5900, 3326, -3449, -10679, -12462, -4029,
                          14915, 38991, 59143, 66990};
  int exp_coef [NTAPS];
  vec_t tbl [10];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic check_coef(input string tag);
    logic signed [CW-1:0] s;
    for (int i = 0; i < NTAPS; i++) begin
      s = coef_flat[i*CW +: CW];
      chk($sformatf("%s b[%0d]", tag, i), s, exp_coef[i]);
    end
  endtask

  task automatic load(input int base, input int nw, input int last_at, input bit gaps);
    for (int i = 0; i < nw; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = CW'(base + i);
      cfg_last  = (i == last_at);
      chk($sformatf("ready word %0d", i), cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
    end
  endtask

  // Issue commit_req in a cycle whose strobe phase is p; the swap waits for
  // the next sam_en cycle, and the ack appears one cycle after the swap.
  task automatic commit(input int p, input bit exp_bank);
    int n;
    int lim;
    lim = 0;
    while ((k % DIV) != p && lim < DIV) begin
      tick();
      lim++;
    end
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n = 1;
    while (commit_ack !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk($sformatf("commit latency p=%0d", p), n, (DIV - 1 - p) + 2);
    chk("bank_sel after swap", bank_sel, exp_bank);
    tick();
    chk("ack single pulse", commit_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 18'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // commit in IDLE
    tbl[1] = '{1'b1, 18'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // word 0
    tbl[2] = '{1'b0, 18'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // gap + commit in LOAD
    tbl[3] = '{1'b1, 18'd101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 18'd102, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // commit in LOAD
    tbl[5] = '{1'b1, 18'd103, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 18'd104, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // last on 5th word
    tbl[7] = '{1'b0, 18'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 18'd5,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // last on first word
    tbl[9] = '{1'b0, 18'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    cfg_last   = 1'b0;
    cfg_abort  = 1'b0;
    commit_req = 1'b0;
    #12;
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset commit_ack", commit_ack, 0);
    chk("reset err_len", err_len, 0);
    chk("reset bank_sel", bank_sel, 0);
    chk("reset sam_en", sam_en, 0);
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = def_tab[i];
    check_coef("reset");

    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("sam_en cycle %0d", c), sam_en, (k % DIV) == DIV - 1);
      tick();
    end

    for (int r = 0; r < 10; r++) begin
      cfg_valid  = tbl[r].v;
      cfg_data   = tbl[r].d;
      cfg_last   = tbl[r].last;
      cfg_abort  = tbl[r].abort;
      commit_req = tbl[r].commit;
      chk($sformatf("vec %0d cfg_ready", r), cfg_ready, tbl[r].exp_ready);
      tick();
      chk($sformatf("vec %0d err_len", r), err_len, tbl[r].exp_err);
      chk($sformatf("vec %0d commit_ack", r), commit_ack, tbl[r].exp_ack);
    end
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    commit_req = 1'b0;
    tick();
    chk("err single pulse", err_len, 0);
    chk("bank_sel after errors", bank_sel, 0);
    check_coef("after errors");

    // Full load then commit at worst-case strobe phase.
    load(1, NTAPS, NTAPS - 1, 1'b0);
    chk("ready in ARMED", cfg_ready, 0);
    tick();
    chk("no ack without commit", commit_ack, 0);
    commit(0, 1'b1);
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = i + 1;
    check_coef("commit 1..11");

    // Gapped load, commit pending, then abort in ARMED.
    load(51, NTAPS, NTAPS - 1, 1'b1);
    chk("ready in ARMED gapped", cfg_ready, 0);
    while ((k % DIV) != 0) tick();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    cfg_abort  = 1'b1;
    tick();
    cfg_abort  = 1'b0;
    chk("ready after abort", cfg_ready, 1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("no ack after abort %0d", c), commit_ack, 0);
      tick();
    end
    chk("bank_sel after abort", bank_sel, 1);
    check_coef("after abort");

    // Load and commit aligned with a strobe cycle.
    load(21, NTAPS, NTAPS - 1, 1'b0);
    commit(3, 1'b0);
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = 21 + i;
    check_coef("commit 21..31");

    // Reset while word 6 of a load is on the bus.
    load(101, 5, -1, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = CW'(106);
    #2;
    reset = 1'b0;
    #1;
    chk("midload reset cfg_ready", cfg_ready, 1);
    chk("midload reset bank_sel", bank_sel, 0);
    chk("midload reset commit_ack", commit_ack, 0);
    chk("midload reset err_len", err_len, 0);
    chk("midload reset sam_en", sam_en, 0);
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = def_tab[i];
    check_coef("midload reset");
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    load(201, NTAPS, NTAPS - 1, 1'b0);
    commit(2, 1'b1);
    for (int i = 0; i < NTAPS; i++) exp_coef[i] = 201 + i;
    check_coef("fresh load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
